// File: rtl/dmem_if.sv
// dmem_if: request/response bus between the core's memory controller and a
// data-memory responder.
//   dmem_addr  : byte address of the request
//   dmem_rmask : read byte mask, nonzero means a read request
//   dmem_wmask : write byte enables, nonzero means a write request
//   dmem_wdata : write data, byte lane i = bits [8i+7:8i]
//   dmem_rdata : read data, valid only while dmem_resp is high
//   dmem_resp  : one-cycle completion pulse
// Modports: master = core/initiator side, slave = memory/responder side.
interface dmem_if;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data-memory responder. Accepts one read, write
// or byte-masked write, holds it for a fixed latency, then pulses dmem_resp
// with the word as it was before any write of that request.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : dmem_if.slave request/response bus
//   busy      : a request is in flight
//   proto_err : one-cycle pulse, the cycle after a request arrived while busy
// Parameters: ADDR_BITS (word-index width), LATENCY (1..15 cycles).
// Optional feature: define DMEM_RESPONDER_RAND_STALL_EN to add 0..3 random
// extra cycles of latency per request, drawn from an 8-bit LFSR.
module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus,
  output logic   busy,
  output logic   proto_err
);

  // Holds LATENCY-1 plus up to 3 stall cycles (max 17).
  localparam int CNT_W = 5;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               proto_err_q, proto_err_d;
  logic               req;
  logic               accept;
  logic               resp;
  logic [1:0]         extra;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]        mem [2**ADDR_BITS];

  assign req = (|bus.dmem_rmask) | (|bus.dmem_wmask);
  assign idx = bus.dmem_addr[ADDR_BITS+1:2];

  // Byte offset and address bits above the array are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.dmem_addr[31:ADDR_BITS+2], bus.dmem_addr[1:0]};

`ifdef DMEM_RESPONDER_RAND_STALL_EN
  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running every cycle.
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'd0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    accept      = 1'b0;
    resp        = 1'b0;
    // Any request seen while in flight (response cycle included) is dropped.
    proto_err_d = req && (state_q == WAIT);
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          // Pre-write word, full 32 bits; the initiator picks its bytes.
          rdata_d = mem[idx];
          cnt_d   = CNT_W'(LATENCY - 1) + CNT_W'(extra);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          resp    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  // NOTE: the array is deliberately not reset so it can map onto an SRAM
  // macro; a write committed before a reset survives it.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.dmem_wmask[b]) mem[idx][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
      end
    end
  end

  // Outputs depend only on registered state, never directly on inputs.
  assign bus.dmem_resp  = resp;
  assign bus.dmem_rdata = resp ? rdata_q : 32'h0;
  assign busy           = (state_q == WAIT);
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
// (ADDR_BITS=10, LATENCY=2), followed by a scoreboard-checked random run.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic proto_err;
  int   tests = 0;
  int   fails = 0;

  dmem_if bus ();

  dmem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
    bus.dmem_addr  = addr;
    bus.dmem_rmask = rm;
    bus.dmem_wmask = wm;
    bus.dmem_wdata = wd;
  endtask

  task automatic clear_req();
    bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic access(input logic [31:0] addr, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd,
                        input bit chk_data, input logic [31:0] exp,
                        input string tag);
    int lat;
    bit lat_ok;
    drive(addr, rm, wm, wd);
    @(negedge clk);
    clear_req();
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!bus.dmem_resp && lat < 24) begin
      @(negedge clk);
      lat++;
    end
`ifdef DMEM_RESPONDER_RAND_STALL_EN
    lat_ok = (lat >= LAT) && (lat <= LAT + 3);
`else
    lat_ok = (lat == LAT);
`endif
    check({tag, " latency_ok"}, 32'(lat_ok), 32'd1);
    if (chk_data) check({tag, " rdata"}, bus.dmem_rdata, exp);
    @(negedge clk);
    check({tag, " idle_after"}, {29'b0, proto_err, busy, bus.dmem_resp}, 32'd0);
  endtask

  logic [31:0] sb [8];

  initial begin
    logic [31:0] wd;
    logic [3:0]  rm, wm;
    int          w;

    rst = 1'b1;
    drive(32'h0, 4'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_state", {bus.dmem_rdata[30:0], bus.dmem_resp}, 32'd0);
    check("reset_flags", {30'b0, busy, proto_err}, 32'd0);
    rst = 1'b0;

    // Idle after reset: all outputs stay low.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_rdata", bus.dmem_rdata, 32'd0);
      check("idle_flags", {29'b0, bus.dmem_resp, busy, proto_err}, 32'd0);
    end

    // Full write, then read back.
    access(32'h0000_0010, 4'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, "wr_full");
    access(32'h0000_0010, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, "rd_full");

    // Byte write via unaligned address; returns the pre-write word.
    access(32'h0000_0012, 4'h0, 4'b0100, 32'h00AA_0000, 1'b1, 32'hDEAD_BEEF, "wr_byte");
    access(32'h0000_0010, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAA_BEEF, "rd_byte");

    // Both masks nonzero: treated as a write, pre-write data returned.
    access(32'h0000_0010, 4'hF, 4'b0001, 32'h0000_0011, 1'b1, 32'hDEAA_BEEF, "rw_both");
    // Address bit 12 lies above the index and aliases onto word 4.
    access(32'h0000_1010, 4'h1, 4'h0, 32'h0, 1'b1, 32'hDEAA_BE11, "rd_alias");

    // Stray write during the response cycle is ignored and flagged.
    drive(32'h0000_0010, 4'hF, 4'h0, 32'h0);
    @(negedge clk);
    clear_req();
    check("perr_wait1", {29'b0, busy, bus.dmem_resp, proto_err}, 32'b100);
    @(negedge clk);
    check("perr_resp", {30'b0, busy, bus.dmem_resp}, 32'b11);
    check("perr_rdata", bus.dmem_rdata, 32'hDEAA_BE11);
    drive(32'h0000_0010, 4'h0, 4'hF, 32'h1234_5678);
    @(negedge clk);
    clear_req();
    check("perr_pulse", {29'b0, busy, bus.dmem_resp, proto_err}, 32'b001);
    @(negedge clk);
    check("perr_clear", {29'b0, busy, bus.dmem_resp, proto_err}, 32'b000);
    access(32'h0000_0010, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAA_BE11, "rd_after_perr");

    // Reset one cycle after accepting a write: response dropped, write kept.
    drive(32'h0000_0040, 4'h0, 4'hF, 32'hCAFE_F00D);
    @(negedge clk);
    clear_req();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", {30'b0, busy, bus.dmem_resp}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_noresp", {30'b0, busy, bus.dmem_resp}, 32'd0);
    end
    access(32'h0000_0040, 4'hF, 4'h0, 32'h0, 1'b1, 32'hCAFE_F00D, "rd_after_rst");

    // Random accesses over 8 words checked against a byte-merge scoreboard.
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      access(32'h100 + 32'(i * 4), 4'h0, 4'hF, wd, 1'b0, 32'h0, "rand_init");
      sb[i] = wd;
    end
    for (int n = 0; n < 200; n++) begin
      w  = int'($urandom_range(0, 7));
      rm = 4'($urandom);
      wm = 4'($urandom_range(0, 1) != 0 ? $urandom : 0);
      if (rm == 4'h0 && wm == 4'h0) rm = 4'hF;
      wd = $urandom;
      access(32'h100 + 32'(w * 4) + 32'($urandom_range(0, 3)), rm, wm, wd,
             1'b1, sb[w], "rand");
      for (int b = 0; b < 4; b++) begin
        if (wm[b]) sb[w][8*b +: 8] = wd[8*b +: 8];
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Single-port data-memory responder: the memory-side end of the core's `dmem_*` request/response interface. It accepts one request (read, write, or byte-masked write), holds it for a fixed latency, then pulses `dmem_resp` with the read data. It sits between the core's memory controller and either a simulation top or an on-chip SRAM macro wrapper. Only one request is in flight at a time. A request that arrives while a request is in flight is a protocol violation and is flagged.

## Interface
Parameters:
- `ADDR_BITS`, default 10: word-index width. The array holds 2^ADDR_BITS 32-bit words (4 KiB at the default).
- `LATENCY`, default 2: cycles from request acceptance to `dmem_resp`. Legal range is 1..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `dmem_addr`  in  32: byte address. Bits [ADDR_BITS+1:2] index the word. Bits [1:0] and bits above ADDR_BITS+1 are ignored.
- `dmem_rmask`  in  4: read byte mask. Nonzero means a read request.
- `dmem_wmask`  in  4: write byte enables. Nonzero means a write request.
- `dmem_wdata`  in  32: write data, byte lane i = bits [8i+7:8i].
- `dmem_rdata`  out  32: read data. Valid only while `dmem_resp`=1.
- `dmem_resp`  out  1: one-cycle completion pulse.
- `busy`  out  1: a request is in flight (WAIT state).
- `proto_err`  out  1: one-cycle pulse when a request arrives while `busy`=1.

## Operation
- A request is present in a cycle when `|dmem_rmask | |dmem_wmask` = 1. Masks are sampled every cycle; the initiator drives them for exactly one cycle per request.
- States: IDLE, WAIT.
- IDLE with a request present: accept the request.
  - If `dmem_wmask`≠0, write each enabled byte lane into the word at the rising edge ending the accept cycle.
  - Capture the pre-write word into the read-data register. Full 32-bit word regardless of `dmem_rmask`; the initiator extracts bytes or halves.
  - Load the counter with LATENCY-1 (plus the extra stall, see Configuration) and go to WAIT.
- WAIT:
  - If the counter is nonzero, decrement it.
  - If the counter is 0: `dmem_resp`=1 and `dmem_rdata` = captured word, combinationally. Return to IDLE at the next edge.
- Both masks nonzero: the request is treated as a write. `dmem_rdata` returns the pre-write word.
- Request present while in WAIT, including the response cycle: the request is ignored (no write, no state change) and `proto_err` pulses the next cycle.
- The array is not reset; contents are undefined until written. Reads of unwritten words return X in simulation.

## Timing
- Reset values: `dmem_resp`=0, `dmem_rdata`=0, `busy`=0, `proto_err`=0, state=IDLE, counter=0.
- Reset asserted mid-request: the pending response is dropped, with no `dmem_resp` afterward. A write already committed at the accept edge stays committed.
- Accept cycle T gives `dmem_resp` high in cycle T+LATENCY (+extra), for exactly one cycle.
- `busy` is high from T+1 through the response cycle inclusive.
- Earliest next accept is response cycle + 1. Back-to-back throughput is one request per LATENCY+1 cycles.
- A write is visible to a read accepted on any later cycle.
- `dmem_rdata` is registered. `dmem_resp` is decoded from registered state and counter, with no input-to-output combinational path.

## Configuration
- `DMEM_RESPONDER_RAND_STALL_EN`, when defined:
  - Adds an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, reset to 8'hA5, advancing every cycle.
  - At accept, extra = `lfsr[1:0]` (0..3) is added to the counter load, so latency is LATENCY..LATENCY+3. This stresses initiator wait handling.
- When undefined: no LFSR is built, extra = 0, and latency is exactly LATENCY.

## Test plan
- Reset, then idle 5 cycles -> `dmem_resp`, `busy`, `proto_err` and `dmem_rdata` all stay 0.
- Write addr 0x0000_0010, wmask 4'hF, wdata 0xDEADBEEF (LATENCY=2) -> `dmem_resp` pulses 2 cycles after accept. Then read addr 0x10, rmask 4'hF -> rdata 0xDEADBEEF.
- Write addr 0x12, wmask 4'b0100, wdata 0x00AA0000 over word 0xDEADBEEF -> a subsequent read of 0x10 returns 0xDEAABEEF. Addr bits [1:0] are ignored.
- Read issued in the second cycle of WAIT -> ignored, `proto_err` pulses once, and the original response still arrives on time with the correct data.
- Assert `rst` one cycle after accepting a write -> no `dmem_resp` follows, `busy`=0 next cycle, and a later read returns the written data.
- With `DMEM_RESPONDER_RAND_STALL_EN`, 200 random accesses checked against a scoreboard -> every latency falls in [LATENCY, LATENCY+3] and all read data matches.
